fpu_issue_queue: RTL and testbench

Upstream instruction issue stage for the FPU top-level decoder. Buffers incoming 32-bit instructions in a small FIFO and presents them one at a time on the decoder's `instruction` input. Holds each instruction until the FPU signals `complete` or `wrong`, or a timeout expires. Inserts one NOP cycle between instructions so the selected arithmetic/conversion unit's enable drops and the next operation restarts cleanly.

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fpu_instr_fifo.sv | 47 ++++
 rtl/fpu_issue_queue.sv | 118 +++++++++++
 tb/tb_fpu_issue_queue.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue path.
// Opcode classes, issue FSM states, the default NOP word.
package fpu_pkg;

    localparam logic [5:0] OP_ARITH = 6'b010001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2
    } issue_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fpu_instr_fifo.sv
// DEPTH x 32 instruction FIFO.
// Pointers carry an extra wrap bit so full and empty differ.
module fpu_instr_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int CW = AW + 1;

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == CW'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer advance; reset discards any queued words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fpu_issue_queue.sv
// Issues buffered instructions to the FPU decoder one at a time,
// holding each until completion, error or timeout, then a NOP gap.
module fpu_issue_queue
    import fpu_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic [31:0] instruction,
    input  logic        fpu_complete,
    input  logic        fpu_wrong,
    output logic        busy,
    output logic [15:0] retired_count,
    output logic [7:0]  err_count,
    output logic        timeout_flag
);

    localparam int AW = $clog2(DEPTH);

    issue_state_t state;
    logic [7:0]   timer;
    logic [31:0]  head;
    logic         full;
    logic         empty;
    logic [AW:0]  count;
    logic         push;
    logic         pop;
    logic         is_arith;
    logic         is_imm;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == ST_IDLE) && !empty;
    assign busy     = (count != '0) || (state != ST_IDLE);
    assign is_arith = (head[31:26] == OP_ARITH);
    assign is_imm   = (head[31:26] == OP_LUI) ||
                      (head[31:26] == OP_ORI);

    fpu_instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_instr),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Issue FSM: pop, hold/wait on the FPU, retire or count errors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            instruction   <= NOP_INSTR;
            timer         <= '0;
            retired_count <= '0;
            err_count     <= '0;
            timeout_flag  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        unique case (1'b1)
                            is_arith: begin
                                instruction <= head;
                                timer       <= '0;
                                state       <= ST_WAIT;
                            end
                            is_imm: begin
                                instruction <= head;
                                state       <= ST_HOLD;
                            end
                            default: begin
                                err_count <= sat_inc8(err_count);
                            end
                        endcase
                    end
                end
                ST_HOLD: begin
                    retired_count <= retired_count + 16'd1;
                    instruction   <= NOP_INSTR;
                    state         <= ST_IDLE;
                end
                ST_WAIT: begin
                    timer <= timer + 8'd1;
                    if (fpu_complete) begin
                        retired_count <= retired_count + 16'd1;
                        instruction   <= NOP_INSTR;
                        state         <= ST_IDLE;
                    end else if (fpu_wrong) begin
                        err_count   <= sat_inc8(err_count);
                        instruction <= NOP_INSTR;
                        state       <= ST_IDLE;
                    end else if (timer == 8'(TIMEOUT - 1)) begin
                        err_count    <= sat_inc8(err_count);
                        timeout_flag <= 1'b1;
                        instruction  <= NOP_INSTR;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    instruction <= NOP_INSTR;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed bench for fpu_issue_queue with an issue-order scoreboard.
// A second instance with TIMEOUT=4 covers the timeout path.
module tb_fpu_issue_queue;

    localparam logic [31:0] W_ARITH = 32'h4600_1040;
    localparam logic [31:0] W_LUI   = 32'h3C01_4000;
    localparam logic [31:0] W_ORI   = 32'h3421_0001;
    localparam logic [31:0] W_ILL   = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic [31:0] instruction;
    logic        fpu_complete = 1'b0;
    logic        fpu_wrong = 1'b0;
    logic        busy;
    logic [15:0] retired_count;
    logic [7:0]  err_count;
    logic        timeout_flag;

    logic        t_valid = 1'b0;
    logic [31:0] t_instr = '0;
    logic        t_ready;
    logic [31:0] t_instruction;
    logic        t_complete = 1'b0;
    logic        t_wrong = 1'b0;
    logic        t_busy;
    logic [15:0] t_retired;
    logic [7:0]  t_err;
    logic        t_tflag;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];
    logic [31:0] prev_instr = '0;

    always #5 clk = ~clk;

    fpu_issue_queue #(
        .DEPTH   (8),
        .TIMEOUT (255)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_ready      (in_ready),
        .instruction   (instruction),
        .fpu_complete  (fpu_complete),
        .fpu_wrong     (fpu_wrong),
        .busy          (busy),
        .retired_count (retired_count),
        .err_count     (err_count),
        .timeout_flag  (timeout_flag)
    );

    fpu_issue_queue #(
        .DEPTH   (8),
        .TIMEOUT (4)
    ) u_to (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (t_valid),
        .in_instr      (t_instr),
        .in_ready      (t_ready),
        .instruction   (t_instruction),
        .fpu_complete  (t_complete),
        .fpu_wrong     (t_wrong),
        .busy          (t_busy),
        .retired_count (t_retired),
        .err_count     (t_err),
        .timeout_flag  (t_tflag)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input bit legal);
        in_valid = 1'b1;
        in_instr = w;
        if (legal) sb.push_back(w);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    // Each new non-NOP word on instruction must be the next legal push.
    always @(negedge clk) begin
        if (instruction !== prev_instr && instruction !== 32'h0) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $error("FAIL sb_unexpected observed=%h expected=none",
                       instruction);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                assert (instruction === e) else begin
                    fails++;
                    $error("FAIL sb_order observed=%h expected=%h",
                           instruction, e);
                end
            end
        end
        prev_instr = instruction;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();

        // reset mid-WAIT with three words queued
        push_word(W_ARITH, 1);
        push_word(W_LUI, 1);
        push_word(W_LUI, 1);
        push_word(W_ORI, 1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        sb.delete();
        chk("rst_instr", instruction, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_retired", 32'(retired_count), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_tflag", 32'(timeout_flag), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_instr", instruction, 32'h0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        tick();

        // LUI then ORI back to back
        in_valid = 1'b1;
        in_instr = W_LUI;
        sb.push_back(W_LUI);
        tick();
        in_instr = W_ORI;
        sb.push_back(W_ORI);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lui_issue", instruction, W_LUI);
        @(negedge clk);
        chk("lui_nop", instruction, 32'h0);
        @(negedge clk);
        chk("ori_issue", instruction, W_ORI);
        @(negedge clk);
        chk("ori_nop", instruction, 32'h0);
        chk("imm_retired", 32'(retired_count), 32'd2);
        tick();

        // ARITH completing five cycles after issue
        push_word(W_ARITH, 1);
        tick();
        @(negedge clk);
        chk("arith_c1", instruction, W_ARITH);
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("arith_c%0d", i), instruction, W_ARITH);
        end
        fpu_complete = 1'b1;
        tick();
        fpu_complete = 1'b0;
        @(negedge clk);
        chk("arith_nop", instruction, 32'h0);
        chk("arith_retired", 32'(retired_count), 32'd3);
        tick();

        // complete and wrong together count as retired
        push_word(W_ARITH, 1);
        tick();
        fpu_complete = 1'b1;
        fpu_wrong = 1'b1;
        tick();
        fpu_complete = 1'b0;
        fpu_wrong = 1'b0;
        @(negedge clk);
        chk("both_nop", instruction, 32'h0);
        chk("both_retired", 32'(retired_count), 32'd4);
        chk("both_err", 32'(err_count), 32'd0);
        tick();

        // timeout on the TIMEOUT=4 instance
        t_valid = 1'b1;
        t_instr = W_ARITH;
        tick();
        t_valid = 1'b0;
        tick();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("to_hold%0d", i), t_instruction, W_ARITH);
        end
        chk("to_flag_early", 32'(t_tflag), 32'd0);
        @(negedge clk);
        chk("to_nop", t_instruction, 32'h0);
        chk("to_flag", 32'(t_tflag), 32'd1);
        chk("to_err", 32'(t_err), 32'd1);
        chk("to_retired", 32'(t_retired), 32'd0);
        tick();

        // fill to full while stalled in WAIT
        push_word(W_ARITH, 1);
        for (int i = 1; i <= 8; i++) begin
            push_word(32'h3C01_0000 + 32'(i), 1);
            chk($sformatf("fill_ready%0d", i),
                32'(in_ready), (i < 8) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b1;
        in_instr = W_ORI;
        sb.push_back(W_ORI);
        tick();
        chk("full_hold", 32'(in_ready), 32'd0);
        fpu_complete = 1'b1;
        tick();
        fpu_complete = 1'b0;
        chk("full_exit", 32'(in_ready), 32'd0);
        tick();
        chk("after_pop_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("ninth_taken", 32'(in_ready), 32'd0);
        wait_idle(200);
        chk("fill_retired", 32'(retired_count), 32'd14);
        tick();

        // illegal word discarded, LUI follows one cycle later
        in_valid = 1'b1;
        in_instr = W_ILL;
        tick();
        in_instr = W_LUI;
        sb.push_back(W_LUI);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("ill_instr", instruction, 32'h0);
        chk("ill_err", 32'(err_count), 32'd1);
        @(negedge clk);
        chk("ill_lui", instruction, W_LUI);
        wait_idle(50);
        chk("ill_retired", 32'(retired_count), 32'd15);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
